// File: rtl/ra_pq_array.sv
// ra_pq_array: register-array priority queue holding up to DEPTH sorted
// key/value entries, with the smallest key at the head. Each cycle it accepts
// one request: enqueue, dequeue, or replace (enqueue together with dequeue).
//
// Optional feature macro: RA_PQ_STABLE_EN
//   defined   -> equal keys leave in arrival order (FIFO among ties)
//   undefined -> a new key is placed ahead of existing equal keys (LIFO)
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   enq, enq_key,     enqueue request carrying a key and a value
//   enq_val
//   deq               dequeue request; removes the head entry
//   head_key/head_val current minimum entry (registered)
//   empty, full       registered occupancy flags
//   count             number of valid entries
//   err               one-cycle pulse after an illegal request
module ra_pq_array #(
    parameter int unsigned KW    = 16,
    parameter int unsigned VW    = 16,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enq,
    input  logic [KW-1:0] enq_key,
    input  logic [VW-1:0] enq_val,
    input  logic          deq,
    output logic [KW-1:0] head_key,
    output logic [VW-1:0] head_val,
    output logic          empty,
    output logic          full,
    output logic [CW-1:0] count,
    output logic          err
);

    localparam logic [KW-1:0] KEYINF = '1;
    localparam logic [VW-1:0] VAL0   = '0;

    logic [KW-1:0] key_q [DEPTH];
    logic [VW-1:0] val_q [DEPTH];
    logic [CW-1:0] count_q;
    logic          empty_q;
    logic          full_q;
    logic          err_q;

    logic [KW-1:0] key_d [DEPTH];
    logic [VW-1:0] val_d [DEPTH];
    logic [CW-1:0] count_d;
    logic          err_d;

    // Base array for insertion: the current array, or the array with the
    // head dropped when replacing.
    logic [KW-1:0] base_key [DEPTH];
    logic [VW-1:0] base_val [DEPTH];
    logic [DEPTH-1:0] ins_here;

    logic enq_ok;
    logic do_enq;
    logic do_deq;
    logic do_rep;

    // True when the new key belongs at or before this slot.
    function automatic logic ins_before(input logic [KW-1:0] slot_key,
                                        input logic [KW-1:0] new_key);
`ifdef RA_PQ_STABLE_EN
        return slot_key > new_key;
`else
        return slot_key >= new_key;
`endif
    endfunction

    // Request classification on the registered state.
    always_comb begin
        enq_ok = enq && (enq_key != KEYINF);
        do_enq = 1'b0;
        do_deq = 1'b0;
        do_rep = 1'b0;
        err_d  = 1'b0;
        if (deq && !empty_q) begin
            if (enq_ok) begin
                do_rep = 1'b1;
            end else begin
                do_deq = 1'b1;
                err_d  = enq;
            end
        end else if (deq) begin
            err_d  = 1'b1;
            do_enq = enq_ok;
        end else if (enq) begin
            if (!enq_ok || full_q) begin
                err_d = 1'b1;
            end else begin
                do_enq = 1'b1;
            end
        end
    end

    // Next array contents. The array is sorted, so ins_here is a thermometer
    // code; the insert position is its lowest set bit.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            if (do_rep) begin
                base_key[i] = (i == DEPTH - 1) ? KEYINF : key_q[(i + 1) % DEPTH];
                base_val[i] = (i == DEPTH - 1) ? VAL0   : val_q[(i + 1) % DEPTH];
            end else begin
                base_key[i] = key_q[i];
                base_val[i] = val_q[i];
            end
            ins_here[i] = ins_before(base_key[i], enq_key);
            key_d[i]    = key_q[i];
            val_d[i]    = val_q[i];
        end
        count_d = count_q;

        if (do_enq || do_rep) begin
            if (ins_here[0]) begin
                key_d[0] = enq_key;
                val_d[0] = enq_val;
            end else begin
                key_d[0] = base_key[0];
                val_d[0] = base_val[0];
            end
            for (int i = 1; i < DEPTH; i++) begin
                if (!ins_here[i]) begin
                    key_d[i] = base_key[i];
                    val_d[i] = base_val[i];
                end else if (!ins_here[i-1]) begin
                    key_d[i] = enq_key;
                    val_d[i] = enq_val;
                end else begin
                    key_d[i] = base_key[i-1];
                    val_d[i] = base_val[i-1];
                end
            end
            if (do_enq) begin
                count_d = count_q + CW'(1);
            end
        end else if (do_deq) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                key_d[i] = key_q[i+1];
                val_d[i] = val_q[i+1];
            end
            key_d[DEPTH-1] = KEYINF;
            val_d[DEPTH-1] = VAL0;
            count_d        = count_q - CW'(1);
        end
    end

    // State registers; flags are registered alongside count.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                key_q[i] <= KEYINF;
                val_q[i] <= VAL0;
            end
            count_q <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                key_q[i] <= key_d[i];
                val_q[i] <= val_d[i];
            end
            count_q <= count_d;
            empty_q <= (count_d == '0);
            full_q  <= (count_d == CW'(DEPTH));
            err_q   <= err_d;
        end
    end

    assign head_key = key_q[0];
    assign head_val = val_q[0];
    assign count    = count_q;
    assign empty    = empty_q;
    assign full     = full_q;
    assign err      = err_q;

endmodule
